path_replayer: RTL and testbench

PATH_REPLAYER -- requirements
Module: path_replayer

---
 rtl/path_replayer_if.sv | 31 +++
 rtl/path_replayer.sv | 185 ++++++++++++++++++
 tb/tb_path_replayer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/path_replayer_if.sv
// -----------------------------------------------------------------------------
// path_replayer_if
// Move-stream handshake between the path replayer and its consumer.
//   mv_data  : replayed direction code (DW bits)
//   mv_valid : mv_data/mv_last are valid
//   mv_ready : consumer accepts the current move
//   mv_last  : current move is the final one of the replay
// Modports: master (replayer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface path_replayer_if #(
  parameter int DW = 2
);
  logic [DW-1:0] mv_data;
  logic          mv_valid;
  logic          mv_ready;
  logic          mv_last;

  modport master (
    output mv_data,
    output mv_valid,
    output mv_last,
    input  mv_ready
  );

  modport slave (
    input  mv_data,
    input  mv_valid,
    input  mv_last,
    output mv_ready
  );
endinterface

// File: rtl/path_replayer.sv
// -----------------------------------------------------------------------------
// path_replayer
// Drains a path stack (goal-to-start order on top) into a local buffer, one
// pop every other cycle, then streams the buffered moves back out in push
// order (start to goal) over a valid/ready interface.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse starting a replay (honoured only in IDLE)
//   stk_dout     : top-of-stack direction
//   stk_empty    : stack holds no entries
//   stk_pop      : one-cycle pop request to the stack
//   mv           : move stream (path_replayer_if.master)
//   path_len     : entries drained in the current/last replay
//   busy         : FSM not in IDLE
//   done         : one-cycle pulse when a replay completes
//   overflow     : stack held more than DEPTH entries (held until next start)
//
// Optional feature macro: PATH_REPLAYER_INVERT_EN
//   When defined, each move is bit-inverted (opposite direction) and the
//   buffer is streamed in drain order (idx counting up) for back-tracing.
// -----------------------------------------------------------------------------
module path_replayer #(
  parameter int DEPTH = 256,
  parameter int DW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DW-1:0]          stk_dout,
  input  logic                   stk_empty,
  output logic                   stk_pop,
  path_replayer_if.master        mv,
  output logic [$clog2(DEPTH):0] path_len,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] buf_q [DEPTH];

  logic          buf_we_s;
  logic [AW:0]   len_m1_s;
  logic [AW-1:0] first_idx_s;
  logic          last_s;
  logic          stream_s;
  logic          xfer_s;

  // Stream bookkeeping: where streaming starts and which index is the final move.
  always_comb begin
    len_m1_s = len_q - LEN_ONE;
`ifdef PATH_REPLAYER_INVERT_EN
    first_idx_s = {AW{1'b0}};
    last_s      = (idx_q == len_m1_s[AW-1:0]);
`else
    // len_q is never 0 when streaming, so len_q-1 always fits in AW bits.
    first_idx_s = len_m1_s[AW-1:0];
    last_s      = (idx_q == {AW{1'b0}});
`endif
    stream_s = (state_q == S_STREAM);
    xfer_s   = stream_s && mv.mv_ready;
  end

  // Next-state logic for the drain/stream FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    buf_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = {(AW+1){1'b0}};
          ovf_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!stk_empty) begin
          if (len_q < LEN_MAX) begin
            buf_we_s = 1'b1;
            len_d    = len_q + LEN_ONE;
            state_d  = S_SETTLE;
          end else begin
            // Buffer full and stack still has entries: stop without popping.
            ovf_d   = 1'b1;
            idx_d   = first_idx_s;
            state_d = S_STREAM;
          end
        end else if (len_q != {(AW+1){1'b0}}) begin
          idx_d   = first_idx_s;
          state_d = S_STREAM;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_SETTLE: begin
        // Gap cycle lets the stack pointer settle before the next sample.
        state_d = S_DRAIN;
      end
      S_STREAM: begin
        if (xfer_s) begin
          if (last_s) begin
            state_d = S_FINISH;
          end else begin
`ifdef PATH_REPLAYER_INVERT_EN
            idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
`else
            idx_d = idx_q - {{(AW-1){1'b0}}, 1'b1};
`endif
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= {(AW+1){1'b0}};
      ovf_q   <= 1'b0;
      idx_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Reversal buffer; contents are only read while streaming a fresh drain.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[len_q[AW-1:0]] <= stk_dout;
    end
  end

  // Output decode from registered state; mv_data is forced to 0 outside STREAM.
  always_comb begin
    stk_pop     = buf_we_s;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FINISH);
    overflow    = ovf_q;
    path_len    = len_q;
    mv.mv_valid = stream_s;
    mv.mv_last  = stream_s && last_s;
    if (stream_s) begin
`ifdef PATH_REPLAYER_INVERT_EN
      mv.mv_data = ~buf_q[idx_q];
`else
      mv.mv_data = buf_q[idx_q];
`endif
    end else begin
      mv.mv_data = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_path_replayer.sv
module tb_path_replayer;
  localparam int DEPTH = 4;
  localparam int DW    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] stk_dout;
  logic          stk_empty;
  logic          stk_pop;
  logic [LW-1:0] path_len;
  logic          busy, done, overflow;

  path_replayer_if #(.DW(DW)) mv_if ();

  path_replayer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stk_dout  (stk_dout),
    .stk_empty (stk_empty),
    .stk_pop   (stk_pop),
    .mv        (mv_if),
    .path_len  (path_len),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural path stack: stk_mem[0] is the oldest push, top is stk_mem[sp-1].
  logic [DW-1:0] stk_mem [16];
  int            sp = 0;
  int            load_n;
  logic          load_go;
  assign stk_empty = (sp == 0);
  assign stk_dout  = (sp > 0) ? stk_mem[4'(sp - 1)] : 2'b00;

  always @(posedge clk) begin
    if (load_go) sp <= load_n;
    else if (stk_pop && sp > 0) sp <= sp - 1;
  end

  // Scoreboard
  logic [DW:0]   exp_q [$];   // {last, data}
  logic [LW:0]   done_q [$];  // {overflow, path_len}
  int            n_chk = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            ready_mode = 0;
  logic [DW-1:0] pat [16];

  // Consumer ready: 0 = always high, 1 = toggle, 2 = random
  initial begin
    mv_if.mv_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       mv_if.mv_ready = 1'b1;
        1:       mv_if.mv_ready = ~mv_if.mv_ready;
        default: mv_if.mv_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  logic          prev_pop = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   e_v;
  logic [LW:0]   d_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pop   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (stk_pop) begin
        n_chk++;
        if (prev_pop || !busy || stk_empty) begin
          n_fail++;
          $display("FAIL pop_rule: prev_pop=%0b busy=%0b empty=%0b, required prev_pop=0 busy=1 empty=0", prev_pop, busy, stk_empty);
        end
      end
      if (prev_stall && mv_if.mv_valid) begin
        n_chk++;
        if (mv_if.mv_data !== prev_data || mv_if.mv_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got data=%b last=%b, required data=%b last=%b", mv_if.mv_data, mv_if.mv_last, prev_data, prev_last);
        end
      end
      if (mv_if.mv_valid && mv_if.mv_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_move: got data=%b, required no move", mv_if.mv_data);
        end else begin
          e_v = exp_q.pop_front();
          if ({mv_if.mv_last, mv_if.mv_data} !== e_v) begin
            n_fail++;
            $display("FAIL move: got last=%b data=%b, required last=%b data=%b", mv_if.mv_last, mv_if.mv_data, e_v[DW], e_v[DW-1:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        n_chk++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          d_v = done_q.pop_front();
          if ({overflow, path_len} !== d_v || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_state: got ovf=%b len=%0d left=%0d, required ovf=%b len=%0d left=0", overflow, path_len, exp_q.size(), d_v[LW], d_v[LW-1:0]);
          end
        end
      end
      prev_pop   = stk_pop;
      prev_stall = mv_if.mv_valid && !mv_if.mv_ready;
      prev_data  = mv_if.mv_data;
      prev_last  = mv_if.mv_last;
    end
  end

  // Load the stack, queue the expected moves and final status from the path rules.
  task automatic prepare(input int n, input bit rnd, output int k);
    logic [DW-1:0] p [16];
    k = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < n; i++) begin
      p[i] = rnd ? DW'($urandom) : pat[i];
      stk_mem[i] = p[i];
    end
`ifdef PATH_REPLAYER_INVERT_EN
    for (int j = n - 1; j >= n - k; j--) exp_q.push_back({(j == n - k), ~p[j]});
`else
    for (int j = n - k; j < n; j++) exp_q.push_back({(j == n - 1), p[j]});
`endif
    done_q.push_back({(n > DEPTH), LW'(k)});
    load_n  = n;
    load_go = 1'b1;
    @(posedge clk); #1;
    load_go = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic run_replay(input int n, input int mode, input bit rnd, input bit inject);
    int k, cyc, base;
    ready_mode = mode;
    base = done_cnt;
    prepare(n, rnd, k);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc > 3000) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: no done after %0d cycles, required done", cyc);
        break;
      end
      start = inject && (cyc == 3);
    end
    start = 1'b0;
    if (mode == 0) begin
      n_chk++;
      if (cyc != 3 * k + 2) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles, required %0d (n=%0d)", cyc, 3 * k + 2, n);
      end
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_cnt != base + 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d pulses, required 1", done_cnt - base);
    end
    n_chk++;
    if (sp != n - k) begin
      n_fail++;
      $display("FAIL stack_left: got %0d entries, required %0d", sp, n - k);
    end
  endtask

  task automatic reset_mid_stream();
    int k, cyc;
    ready_mode = 0;
    prepare(4, 1'b1, k);
    cyc = 0;
    while (!mv_if.mv_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (!mv_if.mv_valid) begin
      n_fail++;
      $display("FAIL reach_stream: got valid=0, required 1");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mv_if.mv_valid, mv_if.mv_last, busy, done, stk_pop, overflow} !== 6'b0 || path_len !== '0 || mv_if.mv_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b len=%0d, required 0 0 0", mv_if.mv_valid, busy, path_len);
    end
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, m;
    rst_n = 1'b0; start = 1'b0; load_go = 1'b0; load_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({stk_pop, mv_if.mv_valid, mv_if.mv_last, busy, done, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000", {stk_pop, mv_if.mv_valid, mv_if.mv_last, busy, done, overflow});
    end
    n_chk++;
    if (path_len !== '0 || mv_if.mv_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got len=%0d data=%b, required 0 00", path_len, mv_if.mv_data);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;

    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11;
    run_replay(3, 0, 1'b0, 1'b0);          // three-entry path
    run_replay(0, 0, 1'b0, 1'b0);          // empty stack
    run_replay(6, 0, 1'b1, 1'b0);          // overflow with DEPTH=4
    run_replay(4, 1, 1'b1, 1'b0);          // toggling ready
    pat[0] = 2'b00; pat[1] = 2'b01;
    run_replay(2, 0, 1'b0, 1'b0);          // two-entry path
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 7);
      m = $urandom_range(0, 2);
      run_replay(n, m, 1'b1, (m == 2) && (n > 0));
    end
    reset_mid_stream();
    run_replay(5, 2, 1'b1, 1'b0);
    run_replay(3, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
